// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared defaults for the systolic-array partial-sum drain path.
//   SYS_DATA_WIDTH : default width of one column partial sum
//   SYS_COLS       : default number of array columns
//   ROW_WIDTH      : packed width of one aligned row at the defaults
//   psum_t         : one column partial sum at the default width
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int SYS_DATA_WIDTH = 32;
  localparam int SYS_COLS       = 4;
  localparam int ROW_WIDTH      = SYS_COLS * SYS_DATA_WIDTH;

  typedef logic [SYS_DATA_WIDTH-1:0] psum_t;

endpackage

// File: rtl/systolic_psum_drain_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding aligned rows for the psum drain.
//   clk, reset  : clock, asynchronous active-high reset (clears pointers+storage)
//   wr_en_i     : write request; accepted when not full, or when full and a
//                 read happens in the same cycle
//   wr_data_i   : row to write
//   rd_en_i     : pop the head row (ignored when empty)
//   rd_data_o   : head row, forced to 0 while empty
//   full_o      : DEPTH rows held
//   empty_o     : no rows held
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = rd_en_i && !empty_o;
  // When full, the write slot is the head slot being popped this cycle.
  assign do_wr = wr_en_i && (!full_o || do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/systolic_psum_drain.sv
// -----------------------------------------------------------------------------
// systolic_psum_drain
// Collects skewed bottom-row partial sums from a systolic array, de-skews them
// into aligned rows, buffers the rows in a FIFO and drains them over a
// valid/ready interface. Never stalls the array: a row arriving at a full FIFO
// with no pop is dropped and the sticky overflow flag set.
//   clk, reset    : clock, asynchronous active-high reset
//   psum_in       : column j at [j*DATA_WIDTH +: DATA_WIDTH], column j of a row
//                   arrives j cycles after psum_valid
//   psum_valid    : column 0 of psum_in is valid this cycle
//   out_data      : head aligned row (0 when empty)
//   out_valid     : out_data holds a row
//   out_ready     : downstream accepts the head row
//   overflow      : sticky, a row was dropped; cleared by reset only
//   rows_drained  : count of accepted rows, wraps modulo 2^16
// Build option: define PSUM_DRAIN_RELU_EN to clamp negative (signed) column
// values to 0 as rows enter the FIFO; latency is unaffected.
// -----------------------------------------------------------------------------
module systolic_psum_drain
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = SYS_DATA_WIDTH,
  parameter int COLS       = SYS_COLS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [COLS*DATA_WIDTH-1:0] psum_in,
  input  logic                       psum_valid,
  output logic [COLS*DATA_WIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overflow,
  output logic [15:0]                rows_drained
);

  localparam int RW = COLS * DATA_WIDTH;

  logic [RW-1:0] aligned_row;
  logic          aligned_vld;
  logic [RW-1:0] wr_row;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          overflow_q;
  logic [15:0]   rows_q;

  // De-skew: column j waits COLS-1-j cycles so every column of a row lines up
  // with the last column, which needs no delay.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_direct
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = psum_in[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly_q [D];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= psum_in[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = dly_q[D-1];
    end
  end

  // Row valid follows column 0 through the full COLS-1 stage delay.
  if (COLS == 1) begin : g_vld_direct
    assign aligned_vld = psum_valid;
  end else begin : g_vld_dly
    logic [COLS-2:0] vld_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= psum_valid;
        for (int k = 1; k < COLS - 1; k++) vld_q[k] <= vld_q[k-1];
      end
    end
    assign aligned_vld = vld_q[COLS-2];
  end

`ifdef PSUM_DRAIN_RELU_EN
  function automatic logic [RW-1:0] relu_row(input logic [RW-1:0] row);
    logic [RW-1:0]                r;
    logic signed [DATA_WIDTH-1:0] v;
    r = row;
    for (int c = 0; c < COLS; c++) begin
      v = row[c*DATA_WIDTH +: DATA_WIDTH];
      if (v < 0) r[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction

  assign wr_row = relu_row(aligned_row);
`else
  assign wr_row = aligned_row;
`endif

  // FIFO write on the edge that ends the aligned cycle; no bypass to output.
  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (aligned_vld),
    .wr_data_i (wr_row),
    .rd_en_i   (pop),
    .rd_data_o (out_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      rows_q     <= '0;
    end else begin
      // A pop in the same cycle frees the slot, so only an unserved full drops.
      if (aligned_vld && fifo_full && !pop) overflow_q <= 1'b1;
      if (pop) rows_q <= rows_q + 16'd1;
    end
  end

  assign overflow     = overflow_q;
  assign rows_drained = rows_q;

endmodule

// File: tb/tb_systolic_psum_drain.sv
module tb_systolic_psum_drain;
  import systolic_pkg::*;

  localparam int DW = SYS_DATA_WIDTH;
  localparam int C  = SYS_COLS;
  localparam int D  = 4;
  localparam int RW = ROW_WIDTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RW-1:0] psum_in = '0;
  logic          psum_valid = 1'b0;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic [15:0]   rows_drained;

  always #5 clk = ~clk;

  systolic_psum_drain #(
    .DATA_WIDTH (DW),
    .COLS       (C),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .psum_in      (psum_in),
    .psum_valid   (psum_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .rows_drained (rows_drained)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: rows are read off the input diagonal, queued, popped.
  int            cyc = 0;
  int            last_rst = 0;
  logic [RW-1:0] bus_hist [16];
  logic          vld_hist [16];
  logic [RW-1:0] mq [$];
  logic          m_ovf = 1'b0;
  logic [15:0]   m_rows = '0;

  logic          s_valid;
  logic [RW-1:0] s_data;
  logic          s_ovf;
  logic [15:0]   s_rows;

  // Directed plan storage
  logic [RW-1:0] plan_bus [32];
  logic          plan_vld [32];
  logic          plan_rdy [32];
  logic          plan_rst [32];
  logic [31:0]   seen_mask;
  logic [RW-1:0] seen_data [32];

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic psum_t model_col(input psum_t v);
`ifdef PSUM_DRAIN_RELU_EN
    if ($signed(v) < 0) return '0;
`endif
    return v;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ovf  = 1'b0;
    m_rows = '0;
  endtask

  // One clock cycle: drive, compare at negedge, advance model at posedge.
  task automatic cycle(input logic v, input logic [RW-1:0] bus, input logic rdy, input logic rst);
    logic          pop;
    logic          wr;
    logic [RW-1:0] row;
    int            t;
    reset      = rst;
    psum_valid = v;
    psum_in    = bus;
    out_ready  = rdy;
    if (rst) model_clear();
    @(negedge clk);
    s_valid = out_valid;
    s_data  = out_data;
    s_ovf   = overflow;
    s_rows  = rows_drained;
    check("out_valid", RW'(s_valid), RW'(mq.size() > 0));
    check("out_data", s_data, (mq.size() > 0) ? mq[0] : '0);
    check("overflow", RW'(s_ovf), RW'(m_ovf));
    check("rows_drained", RW'(s_rows), RW'(m_rows));
    @(posedge clk);
    bus_hist[cyc % 16] = bus;
    vld_hist[cyc % 16] = v;
    if (rst) begin
      model_clear();
      last_rst = cyc;
    end else begin
      pop = (mq.size() > 0) && rdy;
      t   = cyc - (C - 1);
      wr  = 1'b0;
      row = '0;
      if (t > last_rst) wr = vld_hist[t % 16];
      if (wr)
        for (int j = 0; j < C; j++)
          row[j*DW +: DW] = model_col(bus_hist[(t + j) % 16][j*DW +: DW]);
      if (wr && mq.size() == D && !pop) begin
        m_ovf = 1'b1;
      end else begin
        if (pop) begin
          void'(mq.pop_front());
          m_rows = m_rows + 16'd1;
        end
        if (wr) mq.push_back(row);
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [RW-1:0] rand_bus();
    logic [RW-1:0] b;
    for (int j = 0; j < C; j++) b[j*DW +: DW] = $urandom;
    return b;
  endfunction

  task automatic plan_init(input logic rdy);
    for (int k = 0; k < 32; k++) begin
      plan_bus[k] = rand_bus();
      plan_vld[k] = 1'b0;
      plan_rdy[k] = rdy;
      plan_rst[k] = 1'b0;
    end
  endtask

  // Column j of the row goes on the bus j cycles after the valid.
  task automatic place_row(input int t, input logic [RW-1:0] row);
    plan_vld[t] = 1'b1;
    for (int j = 0; j < C; j++) plan_bus[t + j][j*DW +: DW] = row[j*DW +: DW];
  endtask

  task automatic run_plan(input int n);
    seen_mask = '0;
    for (int k = 0; k < n; k++) begin
      cycle(plan_vld[k], plan_bus[k], plan_rdy[k], plan_rst[k]);
      seen_mask[k] = s_valid;
      seen_data[k] = s_data;
    end
  endtask

  task automatic reset_pulse();
    cycle(1'b0, rand_bus(), 1'b0, 1'b1);
  endtask

  function automatic logic [RW-1:0] mk(input int r);
    return {DW'(r*4 + 4), DW'(r*4 + 3), DW'(r*4 + 2), DW'(r*4 + 1)};
  endfunction

  logic [RW-1:0] relu_in;
  logic [RW-1:0] relu_exp;

  initial begin
    @(posedge clk);
    #1;
    reset_pulse();
    reset_pulse();
    // Reset state
    check("reset_valid", RW'(s_valid), '0);
    check("reset_data", s_data, '0);
    check("reset_ovf", RW'(s_ovf), '0);
    check("reset_rows", RW'(s_rows), '0);

    // Single row: valid at 2 -> out_valid only in cycle 6
    plan_init(1'b1);
    place_row(2, {32'd4, 32'd3, 32'd2, 32'd1});
    run_plan(12);
    check("single_mask", RW'(seen_mask[11:0]), RW'(12'h040));
    check("single_data", seen_data[6], {32'd4, 32'd3, 32'd2, 32'd1});
    check("single_rows", RW'(s_rows), RW'(16'd1));

    // Burst of 4 consecutive rows
    reset_pulse();
    plan_init(1'b1);
    for (int r = 0; r < 4; r++) place_row(2 + r, mk(r));
    run_plan(14);
    check("burst_mask", RW'(seen_mask[13:0]), RW'(14'h03C0));
    for (int r = 0; r < 4; r++) check("burst_data", seen_data[6 + r], mk(r));

    // Backpressure: 5 rows into a 4-deep FIFO, then drain
    reset_pulse();
    plan_init(1'b0);
    for (int r = 0; r < 5; r++) place_row(2 + r, mk(r + 8));
    run_plan(12);
    check("bp_ovf", RW'(s_ovf), RW'(1'b1));
    check("bp_head", s_data, mk(8));
    plan_init(1'b1);
    run_plan(8);
    check("bp_drain_mask", RW'(seen_mask[7:0]), RW'(8'h0F));
    for (int r = 0; r < 4; r++) check("bp_drain_data", seen_data[r], mk(r + 8));
    check("bp_ovf_sticky", RW'(s_ovf), RW'(1'b1));
    check("bp_rows", RW'(s_rows), RW'(16'd4));

    // Full FIFO with pop in the cycle the 5th row aligns
    reset_pulse();
    plan_init(1'b0);
    for (int r = 0; r < 5; r++) place_row(2 + r, mk(r + 16));
    for (int k = 9; k < 32; k++) plan_rdy[k] = 1'b1;
    run_plan(20);
    check("simul_mask", RW'(seen_mask[19:0]), RW'(20'h03FC0));
    for (int r = 0; r < 5; r++) check("simul_data", seen_data[9 + r], mk(r + 16));
    check("simul_ovf", RW'(s_ovf), RW'(1'b0));
    check("simul_rows", RW'(s_rows), RW'(16'd5));

    // Reset two cycles into a row; a fresh row afterwards keeps 4-cycle latency
    reset_pulse();
    plan_init(1'b1);
    place_row(2, {32'd4, 32'd3, 32'd2, 32'd1});
    plan_rst[4] = 1'b1;
    place_row(8, mk(40));
    run_plan(16);
    check("rst_mask", RW'(seen_mask[15:0]), RW'(16'h1000));
    check("rst_data", seen_data[12], mk(40));
    check("rst_rows", RW'(s_rows), RW'(16'd1));

    // Signed column values
    relu_in = {32'h80000000, 32'd0, 32'd7, 32'hFFFFFFFB};
`ifdef PSUM_DRAIN_RELU_EN
    relu_exp = {32'd0, 32'd0, 32'd7, 32'd0};
`else
    relu_exp = relu_in;
`endif
    reset_pulse();
    plan_init(1'b1);
    place_row(2, relu_in);
    run_plan(8);
    check("relu_data", seen_data[6], relu_exp);

    // Randomized traffic: heavy backpressure, then light, with rare resets
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 1)), rand_bus(), 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 149) == 0));
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 3) != 0), rand_bus(), 1'($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 149) == 0));
    for (int k = 0; k < 12; k++) cycle(1'b0, rand_bus(), 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_psum_drain.md
SYSTOLIC_PSUM_DRAIN -- requirements
Module: systolic_psum_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the bit width of each column partial sum.
REQ-002 Parameter COLS, default 4, SHALL set the number of array columns drained, valid range 1 to 16.
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the number of aligned rows buffered, power of two, at least 2.
REQ-004 clk  input  1  SHALL be the clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 psum_in  input  COLS*DATA_WIDTH  SHALL carry the bottom-row psum_out of each column, with column j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-007 psum_valid  input  1  SHALL mark that column 0 of psum_in carries a valid result this cycle.
REQ-008 out_data  output  COLS*DATA_WIDTH  SHALL carry the head aligned row, using the same column packing as psum_in.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds a valid row.
REQ-010 out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-011 overflow  output  1  SHALL be a sticky flag indicating that a row was dropped.
REQ-012 rows_drained  output  16  SHALL count the rows accepted downstream and wrap modulo 2^16.

Function
REQ-013 Skewed arrival: when psum_valid is high in cycle t, the result of column j SHALL be taken from psum_in in cycle t+j; the block SHALL impose no stall on the array.
REQ-014 De-skew: column j SHALL pass through COLS-1-j register stages, and psum_valid SHALL pass through COLS-1 stages, so that the row is aligned at the delay-line outputs in cycle t+COLS-1.
REQ-015 The aligned row SHALL be written into the FIFO on the clock edge ending cycle t+COLS-1, and out_valid SHALL rise in cycle t+COLS when the FIFO was empty; there SHALL be no combinational bypass.
REQ-016 psum_valid asserted on consecutive cycles SHALL produce one row per cycle, with no bubbles and rows kept in order.
REQ-017 A handshake SHALL occur when out_valid and out_ready are both high; the head row SHALL then be popped and rows_drained incremented.
REQ-018 While out_valid is high and out_ready is low, out_data SHALL hold stable.
REQ-019 out_valid SHALL NOT depend combinationally on out_ready.
REQ-020 Full FIFO with an aligned write and no pop in the same cycle: the row SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL set.
REQ-021 Full FIFO with an aligned write and a pop in the same cycle: both SHALL occur and overflow SHALL NOT set.
REQ-022 Empty FIFO: out_valid SHALL be 0 and out_data SHALL be 0.
REQ-023 Addition or arithmetic on data SHALL NOT occur; values pass bit-exact, except as specified in REQ-029.
REQ-024 overflow SHALL clear only on reset.
REQ-025 rows_drained SHALL wrap from 16'hFFFF to 0.

Reset
REQ-026 While reset is high, the delay lines, FIFO pointers and storage, overflow, and rows_drained SHALL be 0, and out_valid and out_data SHALL be 0.
REQ-027 Rows in flight in the delay lines or the FIFO when reset asserts SHALL be discarded, and no handshake SHALL occur during reset.
REQ-028 After reset deasserts, the first psum_valid SHALL follow the REQ-015 latency exactly.

Configuration
REQ-029 With macro PSUM_DRAIN_RELU_EN defined, each column value SHALL be interpreted as signed two's complement and replaced by 0 if negative, applied at FIFO write; the latency SHALL be unchanged.
REQ-030 With PSUM_DRAIN_RELU_EN undefined, values SHALL pass unmodified and no ReLU logic SHALL be present.

Structure
REQ-031 Package systolic_pkg SHALL hold the DATA_WIDTH and COLS defaults, a psum_t typedef of logic [DATA_WIDTH-1:0], and a row-width constant COLS*DATA_WIDTH.
REQ-032 FIFO storage and pointers SHALL be a sub-module named sync_fifo, parameterized by width and depth, exposing full and empty.
REQ-033 The de-skew delay lines and the ReLU stage SHALL live in systolic_psum_drain.

Verification (COLS=4, DATA_WIDTH=32, FIFO_DEPTH=4)
REQ-034 Single row: psum_valid in cycle 10 with columns 0..3 = 1, 2, 3, 4 in cycles 10..13 and out_ready=1 -> out_valid high in cycle 14 only, out_data = {4,3,2,1}, and rows_drained = 1.
REQ-035 Burst: psum_valid in cycles 10..13 and out_ready=1 -> out_valid high in cycles 14..17, with rows in order and unchanged.
REQ-036 Backpressure and overflow: out_ready=0 and 5 rows sent -> 4 rows buffered, overflow=1; with out_ready=1 afterwards the first 4 rows drain, the 5th is absent, and overflow stays 1.
REQ-037 Full FIFO, simultaneous pop and write: FIFO full and out_ready=1 in the cycle the 5th row aligns -> overflow stays 0 and all 5 rows emerge.
REQ-038 Reset mid-operation: reset asserted in cycle 12 of a REQ-034 row -> out_valid never rises for that row, and a new row after reset emerges with 4-cycle latency.
REQ-039 ReLU with PSUM_DRAIN_RELU_EN defined: columns = -5, 7, 0, 32'h80000000 -> out_data = {0,0,7,0}; with the macro undefined, the same input -> values unchanged.
